// File: rtl/calc_stream_engine_if.sv
// Memory-side bus of the stream engine: one read port with one-cycle latency and one write port.
interface calc_stream_engine_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int PACK   = 2
);
  logic                   read_o;
  logic [ADDR_W-1:0]      r_addr_o;
  logic [PACK*DATA_W-1:0] r_data_i;
  logic                   write_o;
  logic [ADDR_W-1:0]      w_addr_o;
  logic [PACK*DATA_W-1:0] w_data_o;

  modport master (
    output read_o, r_addr_o, write_o, w_addr_o, w_data_o,
    input  r_data_i
  );

  modport slave (
    input  read_o, r_addr_o, write_o, w_addr_o, w_data_o,
    output r_data_i
  );
endinterface

// File: rtl/calc_stream_engine.sv
// Streams operand pairs from memory, combines each pair (add/sub/saturating add),
// and packs PACK results per word into a circular write window.
module calc_stream_engine #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int PACK   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [ADDR_W-1:0] read_start_addr,
  input  logic [ADDR_W-1:0] read_end_addr,
  input  logic [ADDR_W-1:0] write_start_addr,
  input  logic [ADDR_W-1:0] write_end_addr,
  calc_stream_engine_if.master bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              wrap_o,
  output logic              ovf_o
);
  localparam int MEM_W = PACK * DATA_W;
  localparam int LW    = $clog2(PACK + 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(PACK - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_ACC   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W-1:0] rd_end;
  logic [ADDR_W-1:0] wr_start;
  logic [ADDR_W-1:0] wr_end;
  logic [1:0]        mode_q;
  logic [LW-1:0]     lane;
  logic [MEM_W-1:0]  buffer;
  logic              last_word;
  logic              err_q;
  logic              wrap_q;
  logic              ovf_q;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] result;
  logic              ovf_now;

  assign op_a = bus.r_data_i[MEM_W-1 -: DATA_W];
  assign op_b = bus.r_data_i[DATA_W-1:0];
  assign sum  = {1'b0, op_a} + {1'b0, op_b};

  // Carry-out of the wide sum doubles as the clamp condition for saturating add.
  always_comb begin
    result  = sum[DATA_W-1:0];
    ovf_now = sum[DATA_W];
    case (mode_q)
      2'b01: begin
        result  = op_a - op_b;
        ovf_now = (op_a < op_b);
      end
      2'b10: begin
        if (sum[DATA_W]) result = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= S_IDLE;
      r_ptr     <= '0;
      w_ptr     <= '0;
      rd_end    <= '0;
      wr_start  <= '0;
      wr_end    <= '0;
      mode_q    <= '0;
      lane      <= '0;
      buffer    <= '0;
      last_word <= 1'b0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            r_ptr     <= read_start_addr;
            w_ptr     <= write_start_addr;
            rd_end    <= read_end_addr;
            wr_start  <= write_start_addr;
            wr_end    <= write_end_addr;
            mode_q    <= mode_i;
            lane      <= '0;
            buffer    <= '0;
            last_word <= 1'b0;
            wrap_q    <= 1'b0;
            ovf_q     <= 1'b0;
            // Inverted ranges abort before any memory traffic.
            if ((read_end_addr < read_start_addr) || (write_end_addr < write_start_addr)) begin
              err_q <= 1'b1;
              state <= S_DONE;
            end else begin
              err_q <= 1'b0;
              state <= S_READ;
            end
          end
        end
        S_READ: state <= S_ACC;
        S_ACC: begin
          for (int k = 0; k < PACK; k++) begin
            if (lane == LW'(k)) buffer[k*DATA_W +: DATA_W] <= result;
          end
          lane      <= lane + 1'b1;
          r_ptr     <= r_ptr + 1'b1;
          ovf_q     <= ovf_q | ovf_now;
          last_word <= (r_ptr == rd_end);
          state     <= ((lane == LAST_LANE) || (r_ptr == rd_end)) ? S_WRITE : S_READ;
        end
        S_WRITE: begin
          buffer <= '0;
          lane   <= '0;
          if (w_ptr == wr_end) begin
            w_ptr  <= wr_start;
            wrap_q <= 1'b1;
          end else begin
            w_ptr <= w_ptr + 1'b1;
          end
          state <= last_word ? S_DONE : S_READ;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.read_o   = (state == S_READ);
  assign bus.r_addr_o = r_ptr;
  assign bus.write_o  = (state == S_WRITE);
  assign bus.w_addr_o = w_ptr;
  assign bus.w_data_o = buffer;

  assign busy_o = (state != S_IDLE);
  assign done_o = (state == S_DONE);
  assign err_o  = err_q;
  assign wrap_o = wrap_q;
  assign ovf_o  = ovf_q;
endmodule

// File: doc/calc_stream_engine.md
CALC_STREAM_ENGINE -- requirements
Module: calc_stream_engine

Interface
REQ-001 Parameter ADDR_W, default 9, memory address width in bits.
REQ-002 Parameter DATA_W, default 32, operand and result width in bits.
REQ-003 Parameter PACK, default 2, number of results packed per write word; memory word width MEM_W = PACK*DATA_W.
REQ-004 Port clk_i  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_i  input  1  reset, synchronous and active-low.
REQ-006 Port start_i  input  1  one-cycle request to begin a job; sampled only in IDLE.
REQ-007 Port mode_i  input  2  operation: 00 add, 01 subtract, 10 unsigned saturating add, 11 add.
REQ-008 Ports read_start_addr, read_end_addr, write_start_addr, write_end_addr  input  ADDR_W each  inclusive job address ranges.
REQ-009 Port read_o  output  1  memory read strobe.
REQ-010 Port r_addr_o  output  ADDR_W  read address.
REQ-011 Port r_data_i  input  MEM_W  read data, valid the cycle after read_o; op_a = bits [MEM_W-1:MEM_W-DATA_W], op_b = bits [DATA_W-1:0].
REQ-012 Port write_o  output  1  memory write strobe.
REQ-013 Port w_addr_o  output  ADDR_W  write address.
REQ-014 Port w_data_o  output  MEM_W  packed result word.
REQ-015 Ports busy_o, done_o, err_o, wrap_o, ovf_o  output  1 each  status (see Function).

Function
REQ-016 The FSM SHALL have states IDLE, READ, ACC, WRITE, DONE.
REQ-017 IDLE: on start_i=1, latch all four addresses and mode_i, set r_ptr=read_start_addr, w_ptr=write_start_addr, clear lane index, result buffer, wrap_o, ovf_o, err_o; go to READ.
REQ-018 If read_end_addr < read_start_addr or write_end_addr < write_start_addr at start, set err_o, go to DONE, issue no memory access.
REQ-019 READ: assert read_o for exactly one cycle with r_addr_o=r_ptr; go to ACC.
REQ-020 ACC: compute result from r_data_i per mode, store in buffer lane L (lane 0 = bits [DATA_W-1:0]), increment L and r_ptr.
REQ-021 From ACC go to WRITE if L reaches PACK or r_ptr was read_end; otherwise to READ.
REQ-022 WRITE: assert write_o for exactly one cycle with w_addr_o=w_ptr, w_data_o=buffer; unfilled lanes SHALL be zero; then clear buffer and L.
REQ-023 After WRITE: if w_ptr=write_end, wrap w_ptr to write_start and set wrap_o (sticky), else increment w_ptr.
REQ-024 From WRITE go to DONE if the last read word has been consumed, else READ.
REQ-025 DONE: assert done_o for exactly one cycle, go to IDLE; err_o, wrap_o, ovf_o hold until next accepted start.
REQ-026 busy_o SHALL be 1 in every state except IDLE.
REQ-027 Add: result = (a+b) mod 2^DATA_W; ovf_o sets on carry-out.
REQ-028 Subtract: result = (a-b) mod 2^DATA_W; ovf_o sets when a < b (unsigned).
REQ-029 Saturating add: result = min(a+b, 2^DATA_W-1); ovf_o sets when clamped.
REQ-030 start_i outside IDLE SHALL be ignored; read_o and write_o SHALL never be high in the same cycle.
REQ-031 Per job of N read words: 2N + ceil(N/PACK) cycles from the cycle after start acceptance to DONE entry.
REQ-032 Address pointers SHALL wrap modulo 2^ADDR_W internally; range comparisons use the latched values.

Reset
REQ-033 With rst_i=0 at a rising edge, state SHALL become IDLE and busy_o, done_o, err_o, wrap_o, ovf_o, read_o, write_o SHALL be 0; r_addr_o, w_addr_o, w_data_o, buffer, pointers SHALL be 0.
REQ-034 Reset mid-job SHALL abort with no further memory strobes; no partial word is written.

Verification
REQ-035 DATA_W=32, PACK=2, add, read 0..3 holding (1,2),(3,4),(5,6),(7,8), write 10..11 -> write addr10 data {7,3}, addr11 {15,11}, done_o at cycle 10, ovf_o=0.
REQ-036 Odd count: read 0..2, same data -> addr11 = {0,11}; done after 2*3+2 = 8 cycles.
REQ-037 Subtract (1,2) -> result 0xFFFFFFFF, ovf_o=1; saturating add (0xFFFFFFFF,5) -> 0xFFFFFFFF, ovf_o=1.
REQ-038 Write range 20..20, read 0..3 -> both words written to addr20 in sequence, wrap_o=1 at done.
REQ-039 read_end=1, read_start=5 -> err_o=1, done_o pulse one cycle after DONE entry, read_o/write_o never asserted.
REQ-040 rst_i=0 during second READ of a 4-word job -> next cycle busy_o=0, no write_o afterwards; start_i while busy -> ignored.
